// File: rtl/rfid_spi_pkg.sv
// Shared types and helpers for the MFRC522 register-access SPI master.
package rfid_spi_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  localparam logic [2:0] CS_IDLE = 3'b111;
  localparam int unsigned RD_FLAG_BIT = 7;

  // MFRC522 address byte: read flag, 6-bit register address, reserved zero.
  function automatic logic [7:0] addr_byte(input logic rw, input logic [5:0] addr);
    logic [7:0] b;
    b = {1'b0, addr, 1'b0};
    b[RD_FLAG_BIT] = rw;
    return b;
  endfunction

endpackage

// File: rtl/rfid_spi_sck_gen.sv
// Half-period counter for SCK timing; strobes flag the edge on which SCK toggles.
module rfid_spi_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic          wrap_c;

  assign wrap_c = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_c = wrap_c && !sck;
  assign fall_c = wrap_c && sck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (wrap_c) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rfid_spi_master.sv
// SPI mode-0 register-access master for up to three RFID readers.
// Optional burst continuation is enabled by defining RFID_SPI_BURST_EN.
module rfid_spi_master
  import rfid_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [1:0] cs_sel,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  input  logic       cont,
  output logic       busy,
  output logic       done,
  output logic       byte_done,
  output logic       err,
  output logic [7:0] rdata,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SCK,
  output logic [2:0] CS
);

  state_t      state;
  logic [15:0] tx_sr;
  logic [7:0]  rx_sr;
  logic [2:0]  bit_cnt;
  logic        data_phase;
  logic        last;
  logic        rw_q;
  logic [15:0] tx_load_c;
  logic        sck_en_c;
  logic        sck_phase;
  logic        rise_c;
  logic        fall_c;

  assign tx_load_c = {addr_byte(rw, addr), rw ? 8'h00 : wdata};
  assign sck_en_c  = (state == SETUP) || (state == SHIFT) || (state == HOLD);

  rfid_spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (sck_en_c),
    .sck    (sck_phase),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

`ifndef RFID_SPI_BURST_EN
  logic unused_cont;
  assign unused_cont = cont ^ sck_phase;
`else
  logic unused_phase;
  assign unused_phase = sck_phase;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      data_phase <= 1'b0;
      last       <= 1'b0;
      rw_q       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_done  <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      MOSI       <= 1'b0;
      SCK        <= 1'b0;
      CS         <= CS_IDLE;
    end else begin
      done      <= 1'b0;
      byte_done <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rw_q       <= rw;
            tx_sr      <= tx_load_c;
            bit_cnt    <= '0;
            data_phase <= 1'b0;
            last       <= 1'b0;
            busy       <= 1'b1;
            // Reader index 3 does not exist: complete at once without touching the bus.
            if (cs_sel == 2'd3) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= SETUP;
              CS    <= ~(3'b001 << cs_sel);
              MOSI  <= tx_load_c[15];
            end
          end
        end
        SETUP: begin
          if (rise_c) begin
            state <= SHIFT;
            SCK   <= 1'b1;
            rx_sr <= {rx_sr[6:0], MISO};
          end
        end
        SHIFT: begin
          if (fall_c) begin
            SCK     <= 1'b0;
            tx_sr   <= {tx_sr[14:0], 1'b0};
            MOSI    <= tx_sr[14];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              data_phase <= 1'b1;
              if (data_phase) begin
                byte_done <= 1'b1;
                last      <= 1'b1;
                if (rw_q) rdata <= rx_sr;
              end
            end
          end else if (rise_c) begin
            // The rise slot after the final byte's low phase starts HOLD instead.
            if (last) begin
              state <= HOLD;
            end else begin
              SCK   <= 1'b1;
              rx_sr <= {rx_sr[6:0], MISO};
            end
          end
`ifdef RFID_SPI_BURST_EN
          else if (byte_done && cont) begin
            last        <= 1'b0;
            tx_sr[15:8] <= rw_q ? 8'h00 : wdata;
            MOSI        <= rw_q ? 1'b0 : wdata[7];
          end
`endif
        end
        HOLD: begin
          if (fall_c) begin
            state <= DONE;
            done  <= 1'b1;
            CS    <= CS_IDLE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rfid_spi_master.md
# rfid_spi_master

Register-access SPI master between the system's control logic and the MFRC522-class RFID readers on the bicycle-rack SPI bus (MISO, MOSI, SCK, CS[2:0]). It accepts single-register read or write requests and serialises each as a 16-bit SPI mode-0 frame: address byte, then data byte. It selects one of three readers and returns read data with a one-cycle completion pulse.

## Interface
- CLK_DIV, 4: SCK half-period in clk cycles, ≥2; SCK = clk_freq/(2·CLK_DIV).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; accepted only when busy=0.
- rw  in  1  1 = read, 0 = write; sampled with start.
- cs_sel  in  2  reader index 0..2; sampled with start.
- addr  in  6  reader register address; sampled with start.
- wdata  in  8  write data (write, or burst next byte); sampled with start or burst continuation.
- cont  in  1  burst continue request (RFID_SPI_BURST_EN only; otherwise ignored).
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at end of transaction.
- byte_done  out  1  one-cycle pulse after each data byte.
- err  out  1  valid with done; 1 = cs_sel was 3.
- rdata  out  8  last received data byte; stable from done until next accepted start.
- MISO  in  1  serial data from reader.
- MOSI  out  1  serial data to reader.
- SCK  out  1  SPI clock, idle low.
- CS  out  3  active-low chip selects, one-hot-low while active.

## Operation
- Reset values: busy=0, done=0, byte_done=0, err=0, rdata=0x00, MOSI=0, SCK=0, CS=3'b111; state IDLE. Reset mid-frame aborts immediately with the same values; no partial rdata update.
- Address byte: {rw, addr[5:0], 1'b0}, MSB first. Write: data byte = wdata. Read: MOSI data byte = 0x00 and MISO bits shift into rdata MSB first.
- States: IDLE → SETUP → SHIFT → HOLD → DONE → IDLE.
- IDLE: start=1 latches rw/cs_sel/addr/wdata. cs_sel=3 → DONE directly, err=1, CS stays high, no SCK. Otherwise → SETUP.
- SETUP: CS[cs_sel]=0, MOSI=address MSB, CLK_DIV cycles.
- SHIFT: 16 bits (24, 32, … in burst). SCK low CLK_DIV cycles, high CLK_DIV cycles. MISO is sampled on the cycle SCK rises. MOSI changes on the cycle SCK falls.
- HOLD: SCK low, CS still low, CLK_DIV cycles. Then CS=111 on entry to DONE.
- DONE: done=1 for one cycle, rdata valid, err valid; then IDLE with busy=0.
- busy=1 from the cycle after start is accepted through the DONE cycle. start while busy is ignored, including start in the DONE cycle.
- byte_done pulses on the cycle the last SCK falling edge of each data byte occurs.

## Timing
- Start accepted at cycle 0. CS falls at cycle 1. First SCK rise at cycle 1+CLK_DIV.
- Single frame: done at cycle 1+34·CLK_DIV (CLK_DIV=4 → cycle 137).
- Invalid cs_sel: done (err=1) at cycle 1.
- Back-to-back: the earliest next accepted start is the cycle after done. CS is high for at least 1 cycle between frames.
- Each burst byte adds 16·CLK_DIV cycles.

## Configuration
- RFID_SPI_BURST_EN defined: cont is sampled at each byte_done. If cont=1, wdata is latched, CS stays low and another 8 bits shift. rdata holds the most recent byte (valid at byte_done). If cont=0, go to HOLD.
- Not defined: cont is ignored. The frame is always exactly 16 bits and the port still exists.

## Structure
- Package rfid_spi_pkg: state enum (IDLE, SETUP, SHIFT, HOLD, DONE), CS_IDLE=3'b111, the read-flag bit position, and a function forming the address byte.
- One sub-module, rfid_spi_sck_gen: half-period counter producing the SCK level, a rise strobe and a fall strobe. It is enabled only in SETUP/SHIFT/HOLD.

## Test plan
- Write, cs_sel=0, addr=0x01, wdata=0x0F, CLK_DIV=4 → CS=110 cycles 1–136; MOSI sampled at SCK rises = 0x02 then 0x0F; done at cycle 137; err=0.
- Read, cs_sel=2, addr=0x37, MISO driven 0xA5 during the data byte → address byte 0xEE, MOSI data 0x00, rdata=0xA5 at done, CS=011 during frame.
- start with cs_sel=3 → done and err=1 at cycle 1; CS stays 111; SCK never toggles.
- start pulsed at cycles 50 and 137 (DONE) during a frame → both ignored; exactly one done; next start accepted at cycle 138.
- rst asserted at cycle 60 → CS=111, SCK=0, busy=0 immediately; no done pulse; rdata unchanged at 0x00.
- With RFID_SPI_BURST_EN, read with cont=1 at the first byte_done, MISO 0x12 then 0x34 → byte_done twice; rdata 0x12 then 0x34; done at cycle 1+50·CLK_DIV.
